// File: rtl/board_update_scheduler.sv
// Purpose : arbitrates tic-tac-toe move requests from two players and defers board writes to vertical blanking.
// Latency : gnt/rej one edge after a request is evaluated in IDLE; board write two edges after gnt when vblank is already high.
// Backpressure: requests are held by the players; while a move is pending (busy) they stall with no gnt/rej.
//
// Ports:
//   i_pixel_clk             sole clock, rising edge
//   i_rst_n                 asynchronous active-low reset
//   i_vcounter[10:0]        vertical line count; vblank when >= VLINES
//   i_req_p1 / i_req_p2     move requests, held until gnt or rej
//   i_cell_p1 / i_cell_p2   target cell 0..8 (row-major), valid while the matching req is high
//   i_clear_req             single-cycle new-game pulse, applied at the next vblank
//   o_gnt_p1 / o_gnt_p2     one-cycle pulse: move captured into the pending slot
//   o_rej_p1 / o_rej_p2     one-cycle pulse: move refused (bad index or occupied cell)
//   o_board[17:0]           cell n at [2n+1:2n]; 00 empty, 01 X (player 1), 10 O (player 2)
//   o_busy                  a move is pending (HOLD or COMMIT)
//   o_commit                one-cycle pulse on the cycle the board takes the pending move
//   o_cleared               one-cycle pulse on the cycle the board is zeroed
module board_update_scheduler #(
  parameter int unsigned VLINES = 480
) (
  input  logic        i_pixel_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_vcounter,
  input  logic        i_req_p1,
  input  logic        i_req_p2,
  input  logic [3:0]  i_cell_p1,
  input  logic [3:0]  i_cell_p2,
  input  logic        i_clear_req,
  output logic        o_gnt_p1,
  output logic        o_gnt_p2,
  output logic        o_rej_p1,
  output logic        o_rej_p2,
  output logic [17:0] o_board,
  output logic        o_busy,
  output logic        o_commit,
  output logic        o_cleared
);

  localparam logic [10:0] VLINES_W = 11'(VLINES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [17:0] r_board;
  logic        r_slot_p2;     // pending move belongs to player 2
  logic [3:0]  r_slot_cell;
  logic        r_clear_pend;
  logic        r_last_p2;     // last gnt/rej went to player 2
  logic        r_gnt_p1;
  logic        r_gnt_p2;
  logic        r_rej_p1;
  logic        r_rej_p2;
  logic        r_commit;
  logic        r_cleared;

  logic        w_vblank;
  logic        w_do_clear;
  logic        w_sel_vld;
  logic        w_sel_p2;
  logic [3:0]  w_sel_cell;
  logic        w_sel_free;
  logic        w_eval;
  logic        w_accept;
  logic        w_refuse;
  logic        w_gnt_p1;
  logic        w_gnt_p2;
  logic        w_rej_p1;
  logic        w_rej_p2;
  logic        w_commit;
  logic [17:0] w_board_nxt;

  assign w_vblank   = (i_vcounter >= VLINES_W);
  // A pending clear fires on the first vblank cycle and takes priority over
  // everything else that cycle, including a commit and request evaluation.
  assign w_do_clear = r_clear_pend & w_vblank;

  // Arbitration: on a tie, serve the player who was not answered last.
  always_comb begin
    w_sel_vld  = i_req_p1 | i_req_p2;
    w_sel_p2   = (i_req_p1 & i_req_p2) ? ~r_last_p2 : i_req_p2;
    w_sel_cell = w_sel_p2 ? i_cell_p2 : i_cell_p1;
  end

  // Index > 8 never matches, so it reads as "not free" and is refused.
  always_comb begin
    w_sel_free = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (w_sel_cell == 4'(n)) begin
        w_sel_free = (r_board[2*n +: 2] == 2'b00);
      end
    end
  end

  // Requests are only answered in IDLE; on the clear cycle they stay held and
  // are evaluated against the cleared board on the following cycle.
  assign w_eval   = (r_state == S_IDLE) & ~w_do_clear & w_sel_vld;
  assign w_accept = w_eval & w_sel_free;
  assign w_refuse = w_eval & ~w_sel_free;

  // FSM: state register
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. COMMIT re-checks vblank so a move reaching COMMIT on the
  // last blanking line falls back to HOLD instead of writing in active video.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_do_clear)    w_state_nxt = S_IDLE;
        else if (w_vblank) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        if (w_do_clear)    w_state_nxt = S_IDLE;
        else if (w_vblank) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (next values of the registered pulses and board)
  always_comb begin
    w_gnt_p1    = w_accept & ~w_sel_p2;
    w_gnt_p2    = w_accept &  w_sel_p2;
    w_rej_p1    = w_refuse & ~w_sel_p2;
    w_rej_p2    = w_refuse &  w_sel_p2;
    w_commit    = (r_state == S_COMMIT) & w_vblank & ~w_do_clear;
    w_board_nxt = r_board;
    if (w_do_clear) begin
      w_board_nxt = 18'd0;
    end else if (w_commit) begin
      for (int n = 0; n < 9; n++) begin
        if (r_slot_cell == 4'(n)) begin
          w_board_nxt[2*n +: 2] = r_slot_p2 ? 2'b10 : 2'b01;
        end
      end
    end
  end

  // Datapath and registered pulses
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_board      <= 18'd0;
      r_slot_p2    <= 1'b0;
      r_slot_cell  <= 4'd0;
      r_clear_pend <= 1'b0;
      r_last_p2    <= 1'b1;
      r_gnt_p1     <= 1'b0;
      r_gnt_p2     <= 1'b0;
      r_rej_p1     <= 1'b0;
      r_rej_p2     <= 1'b0;
      r_commit     <= 1'b0;
      r_cleared    <= 1'b0;
    end else begin
      r_board   <= w_board_nxt;
      r_gnt_p1  <= w_gnt_p1;
      r_gnt_p2  <= w_gnt_p2;
      r_rej_p1  <= w_rej_p1;
      r_rej_p2  <= w_rej_p2;
      r_commit  <= w_commit;
      r_cleared <= w_do_clear;

      // A clear_req arriving on the clear cycle itself is absorbed.
      if (w_do_clear)       r_clear_pend <= 1'b0;
      else if (i_clear_req) r_clear_pend <= 1'b1;

      if (w_eval) r_last_p2 <= w_sel_p2;

      if (w_do_clear) begin
        r_slot_p2   <= 1'b0;
        r_slot_cell <= 4'd0;
      end else if (w_accept) begin
        r_slot_p2   <= w_sel_p2;
        r_slot_cell <= w_sel_cell;
      end
    end
  end

  assign o_gnt_p1  = r_gnt_p1;
  assign o_gnt_p2  = r_gnt_p2;
  assign o_rej_p1  = r_rej_p1;
  assign o_rej_p2  = r_rej_p2;
  assign o_board   = r_board;
  assign o_busy    = (r_state != S_IDLE);
  assign o_commit  = r_commit;
  assign o_cleared = r_cleared;

endmodule

// File: tb/tb_board_update_scheduler.sv
module tb_board_update_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] vcounter;
  logic        req_p1, req_p2;
  logic [3:0]  cell_p1, cell_p2;
  logic        clear_req;
  logic        gnt_p1, gnt_p2, rej_p1, rej_p2;
  logic [17:0] board;
  logic        busy, commit, cleared;

  board_update_scheduler #(.VLINES(480)) dut (
    .i_pixel_clk (clk),
    .i_rst_n     (rst_n),
    .i_vcounter  (vcounter),
    .i_req_p1    (req_p1),
    .i_req_p2    (req_p2),
    .i_cell_p1   (cell_p1),
    .i_cell_p2   (cell_p2),
    .i_clear_req (clear_req),
    .o_gnt_p1    (gnt_p1),
    .o_gnt_p2    (gnt_p2),
    .o_rej_p1    (rej_p1),
    .o_rej_p2    (rej_p2),
    .o_board     (board),
    .o_busy      (busy),
    .o_commit    (commit),
    .o_cleared   (cleared)
  );

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: the board as an array of player numbers (0 none, 1, 2),
  // a pending move, whether its first vblank cycle has been seen, clear flag.
  int  m_cell[9];
  bit  m_pend;
  int  m_pend_pl;
  int  m_pend_cell;
  bit  m_armed;
  bit  m_clr_pend;
  int  m_last;
  bit  e_gnt1, e_gnt2, e_rej1, e_rej2, e_commit, e_cleared;

  function automatic logic [17:0] m_board_vec();
    logic [17:0] v;
    v = '0;
    for (int n = 0; n < 9; n++) v[2*n +: 2] = 2'(m_cell[n]);
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 9; n++) m_cell[n] = 0;
    m_pend = 0; m_pend_pl = 0; m_pend_cell = 0; m_armed = 0;
    m_clr_pend = 0; m_last = 2;
    e_gnt1 = 0; e_gnt2 = 0; e_rej1 = 0; e_rej2 = 0; e_commit = 0; e_cleared = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit vb;
    int who;
    int c;
    vb = (vcounter >= 11'd480);
    e_gnt1 = 0; e_gnt2 = 0; e_rej1 = 0; e_rej2 = 0; e_commit = 0; e_cleared = 0;
    if (m_clr_pend && vb) begin
      for (int n = 0; n < 9; n++) m_cell[n] = 0;
      m_pend = 0; m_armed = 0; m_clr_pend = 0; e_cleared = 1;
    end else begin
      if (m_pend) begin
        if (m_armed && vb) begin
          m_cell[m_pend_cell] = m_pend_pl;
          m_pend = 0; m_armed = 0; e_commit = 1;
        end else if (m_armed) begin
          m_armed = 0;
        end else if (vb) begin
          m_armed = 1;
        end
      end else begin
        who = 0;
        if (req_p1 && req_p2) who = (m_last == 2) ? 1 : 2;
        else if (req_p1)      who = 1;
        else if (req_p2)      who = 2;
        if (who != 0) begin
          c = (who == 1) ? int'(cell_p1) : int'(cell_p2);
          m_last = who;
          if (c > 8 || m_cell[c] != 0) begin
            if (who == 1) e_rej1 = 1; else e_rej2 = 1;
          end else begin
            if (who == 1) e_gnt1 = 1; else e_gnt2 = 1;
            m_pend = 1; m_pend_pl = who; m_pend_cell = c;
          end
        end
      end
      if (clear_req) m_clr_pend = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    n_tot++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".board"},   board, m_board_vec());
    chk({tag, ".busy"},    {17'd0, busy},    {17'd0, m_pend});
    chk({tag, ".gnt_p1"},  {17'd0, gnt_p1},  {17'd0, e_gnt1});
    chk({tag, ".gnt_p2"},  {17'd0, gnt_p2},  {17'd0, e_gnt2});
    chk({tag, ".rej_p1"},  {17'd0, rej_p1},  {17'd0, e_rej1});
    chk({tag, ".rej_p2"},  {17'd0, rej_p2},  {17'd0, e_rej2});
    chk({tag, ".commit"},  {17'd0, commit},  {17'd0, e_commit});
    chk({tag, ".cleared"}, {17'd0, cleared}, {17'd0, e_cleared});
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst_n = 1'b0; vcounter = '0; req_p1 = 0; req_p2 = 0;
    cell_p1 = '0; cell_p2 = '0; clear_req = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Single move deferred to vblank, cell 4
    vcounter = 11'd100; req_p1 = 1; cell_p1 = 4'd4;
    tick("mv4_gnt");
    req_p1 = 0;
    ticks("mv4_hold", 3);
    vcounter = 11'd479; tick("mv4_479");
    vcounter = 11'd480; tick("mv4_480");
    tick("mv4_commit");
    chk("mv4_cell", {16'd0, board[9:8]}, 18'd1);
    vcounter = 11'd0; tick("mv4_after");

    // Tie after reset: player 1 first, then player 2 refused on occupied cell 0
    rst_n = 1'b0; #1; model_reset(); check_all("reset2"); rst_n = 1'b1;
    req_p1 = 1; req_p2 = 1; cell_p1 = 4'd0; cell_p2 = 4'd0; vcounter = 11'd100;
    tick("tie_gnt");
    req_p1 = 0;
    ticks("tie_stall", 3);
    vcounter = 11'd480;
    ticks("tie_commit", 2);
    tick("tie_rej");
    chk("tie_rej_p2", {17'd0, rej_p2}, 18'd1);
    chk("tie_cell0", {16'd0, board[1:0]}, 18'd1);
    req_p2 = 0;

    // Out-of-range cell indices refused
    vcounter = 11'd100;
    req_p2 = 1; cell_p2 = 4'd9;  tick("idx9");  req_p2 = 0; tick("idx9_idle");
    req_p2 = 1; cell_p2 = 4'd15; tick("idx15"); req_p2 = 0; tick("idx15_idle");

    // Request during vblank: commit two edges after gnt
    vcounter = 11'd490; req_p2 = 1; cell_p2 = 4'd8;
    tick("vb_gnt"); req_p2 = 0;
    tick("vb_commit_state");
    tick("vb_commit");
    chk("vb_cell8", {16'd0, board[17:16]}, 18'd2);

    // Move reaching COMMIT on the last blanking line waits for next frame
    vcounter = 11'd100; req_p1 = 1; cell_p1 = 4'd5;
    tick("late_gnt"); req_p1 = 0;
    vcounter = 11'd524; tick("late_524");
    vcounter = 11'd0;   ticks("late_active", 3);
    vcounter = 11'd480; ticks("late_commit", 2);

    // Clear beats pending move; second clear_req absorbed
    vcounter = 11'd200; req_p1 = 1; cell_p1 = 4'd2;
    tick("clr_gnt"); req_p1 = 0;
    clear_req = 1; tick("clr_req1"); clear_req = 0; tick("clr_wait");
    clear_req = 1; tick("clr_req2"); clear_req = 0;
    vcounter = 11'd480; tick("clr_fire");
    chk("clr_board", board, 18'd0);
    ticks("clr_after", 3);

    // Asynchronous reset while a move on cell 3 is held
    vcounter = 11'd200; req_p1 = 1; cell_p1 = 4'd3;
    tick("rst_gnt"); req_p1 = 0;
    tick("rst_hold");
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all("rst_async");
    #2 rst_n = 1'b1;
    vcounter = 11'd480; ticks("rst_vblank", 4);
    chk("rst_board", board, 18'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick("rand");
      if (e_gnt1 || e_rej1) req_p1 = 0;
      if (e_gnt2 || e_rej2) req_p2 = 0;
      if (!req_p1 && $urandom_range(0, 3) == 0) begin
        req_p1 = 1;
        cell_p1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
      if (!req_p2 && $urandom_range(0, 3) == 0) begin
        req_p2 = 1;
        cell_p2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
      clear_req = ($urandom_range(0, 60) == 0);
      vcounter = vcounter + 11'($urandom_range(0, 12));
      if (vcounter >= 11'd525) vcounter = vcounter - 11'd525;
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/board_update_scheduler.md
BOARD_UPDATE_SCHEDULER -- requirements
Module: board_update_scheduler

Interface
REQ-001 Parameter VLINES, default 480: first vcounter value of vertical blanking; commits occur only when vcounter >= VLINES.
REQ-002 pixel_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 vcounter  input  11  vertical line count from the 640x480 timing generator.
REQ-005 req_p1, req_p2  input  1 each  move request from player 1 / player 2; held until gnt or rej.
REQ-006 cell_p1, cell_p2  input  4 each  target cell index, 0..8, row-major; valid while matching req high.
REQ-007 clear_req  input  1  single-cycle pulse requesting a new-game board clear.
REQ-008 gnt_p1, gnt_p2  output  1 each  one-cycle pulse; move accepted into pending slot.
REQ-009 rej_p1, rej_p2  output  1 each  one-cycle pulse; move refused.
REQ-010 board  output  18  2 bits per cell, cell n at [2n+1:2n]; 00 empty, 01 X (player 1), 10 O (player 2); 11 never driven.
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 commit  output  1  one-cycle pulse on the cycle board takes a move.
REQ-013 cleared  output  1  one-cycle pulse on the cycle board is zeroed by clear.

Function
REQ-014 vblank SHALL be (vcounter >= VLINES), used combinationally.
REQ-015 FSM states: IDLE, HOLD, COMMIT; one pending slot {player, cell}.
REQ-016 IDLE, exactly one req high: if cell > 8 or board cell != 00, pulse rej for that player, stay IDLE; else capture slot, pulse gnt, go HOLD.
REQ-017 IDLE, both req high: evaluate only the player not granted/rejected last (last_served reset to player 2, so player 1 wins first tie); other player gets no response that cycle.
REQ-018 last_served SHALL update on every gnt or rej.
REQ-019 HOLD: stay while vblank low; go COMMIT on first cycle vblank high.
REQ-020 COMMIT: write slot player code into board cell, pulse commit, go IDLE.
REQ-021 Requests in HOLD or COMMIT SHALL receive neither gnt nor rej (stall); evaluated on return to IDLE against updated board.
REQ-022 Request in IDLE with vblank already high: gnt at cycle T, COMMIT state at T+1, board updated and commit at T+2 edge.
REQ-023 Move arriving at vblank end SHALL wait in HOLD for next frame's vblank; no board change during active video.
REQ-024 clear_req in any state SHALL set clear_pend; new clear_req while clear_pend set is absorbed.
REQ-025 On first cycle with clear_pend and vblank high: board <= 0, pulse cleared, clear_pend <= 0, pending slot discarded, state <= IDLE; no commit that cycle (clear beats commit).
REQ-026 Request evaluated in IDLE while clear_pend set SHALL use current (uncleared) board.
REQ-027 gnt, rej, commit, cleared SHALL be registered outputs; never two of gnt_p1/gnt_p2/rej_p1/rej_p2 high together.
REQ-028 board SHALL change only at commit or clear, never in active video.

Reset
REQ-029 rst_n low SHALL immediately force: board 0, state IDLE, slot cleared, clear_pend 0, last_served player 2, all pulses 0, busy 0.
REQ-030 Reset mid-HOLD/COMMIT SHALL discard the pending move; no commit after release.
REQ-031 After rst_n rises, first evaluation occurs on the next rising edge.

Verification
REQ-032 vcounter=100, req_p1 cell 4 -> gnt_p1 pulse, busy 1, board 0 until vcounter reaches 480, then board[9:8]=01, commit pulse, busy 0.
REQ-033 After reset both req, cell_p1=0, cell_p2=0 -> gnt_p1; after commit, player 2 evaluated -> rej_p2 (cell 0 occupied), board[1:0]=01.
REQ-034 req_p2 cell 9 -> rej_p2 next edge, board unchanged, busy 0; cell 15 same.
REQ-035 vcounter=490, IDLE, req_p2 cell 8 -> gnt_p2 at T, board[17:16]=10 and commit at T+2.
REQ-036 Move pending in HOLD plus clear_req at vcounter=200 -> at vcounter 480 board=0, cleared pulse, no commit, state IDLE.
REQ-037 rst_n low while in HOLD with cell 3 pending -> outputs 0 asynchronously; subsequent vblank leaves board 0, no commit.
